// File: rtl/uart_word_packer.sv
// Packs four UART bytes (first byte in [31:24]) into a 32-bit word and presents it on a valid/ready port.
// Stale partial words are dropped after an inter-byte timeout; words that find the output register busy are dropped.
module uart_word_packer #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned UART_BAUD    = 115200,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        overrun
);

    localparam int unsigned TIMEOUT_CYCLES = (CLK_FREQ / UART_BAUD) * TIMEOUT_BITS;
    localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [1:0]       byte_cnt, byte_cnt_nxt;
    logic [31:0]      shift, shift_nxt;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [31:0]      word_data_nxt;
    logic             word_valid_nxt;
    logic             frame_err_nxt;
    logic             overrun_nxt;
    logic             word_done;
    logic             timeout;
    logic [31:0]      word_full;

    // Completed word: the 4th byte is still on rx_data when the word finishes
    assign word_full = {shift[31:8], rx_data};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            byte_cnt   <= 2'd0;
            shift      <= 32'd0;
            tmo_cnt    <= '0;
            word_data  <= 32'd0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= byte_cnt_nxt;
            shift      <= shift_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            word_data  <= word_data_nxt;
            word_valid <= word_valid_nxt;
            frame_err  <= frame_err_nxt;
            overrun    <= overrun_nxt;
        end
    end

    // Assembly, timeout and output-register control
    always_comb begin
        state_nxt      = state;
        byte_cnt_nxt   = byte_cnt;
        shift_nxt      = shift;
        tmo_cnt_nxt    = tmo_cnt;
        word_data_nxt  = word_data;
        word_valid_nxt = word_valid;
        overrun_nxt    = 1'b0;
        word_done      = 1'b0;

        // An arriving byte always beats the timeout in the same cycle
        timeout = (state == COLLECT) && !rx_done
                  && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        frame_err_nxt = timeout;

        if (rx_done) begin
            tmo_cnt_nxt  = '0;
            byte_cnt_nxt = byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    shift_nxt[31:24] = rx_data;
                2'd1:    shift_nxt[23:16] = rx_data;
                2'd2:    shift_nxt[15:8]  = rx_data;
                default: shift_nxt[7:0]   = rx_data;
            endcase
            if (byte_cnt == 2'd3) begin
                word_done = 1'b1;
                state_nxt = IDLE;
            end else begin
                state_nxt = COLLECT;
            end
        end else if (state == COLLECT) begin
            if (timeout) begin
                state_nxt    = IDLE;
                byte_cnt_nxt = 2'd0;
                tmo_cnt_nxt  = '0;
            end else begin
                tmo_cnt_nxt = CNT_W'(tmo_cnt + 1'b1);
            end
        end

        // A word freed this cycle makes room for the new one
        if (word_done) begin
            if (!word_valid || word_ready) begin
                word_data_nxt  = word_full;
                word_valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (word_valid && word_ready) begin
            word_valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_word_packer.sv
// Bench for uart_word_packer: vector table, directed corner sequences and a random run
// against a byte-queue reference model.
module tb_uart_word_packer;

    localparam int TMO = 8680;   // (50e6/115200 truncated = 434) * 20 bit times

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_done = 1'b0;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        frame_err;
    logic        overrun;

    uart_word_packer dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    int tests  = 0;
    int errors = 0;
    int fe_seen = 0;
    int ov_seen = 0;

    // Reference model state
    logic [7:0]  m_bytes[$];
    int          m_gap = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic        m_fe = 1'b0;
    logic        m_ov = 1'b0;

    typedef struct {
        logic        rd;
        logic [7:0]  d;
        logic        rdy;
        logic        v;
        logic [31:0] data;
        logic        fe;
        logic        ov;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_bytes.delete();
        m_gap   = 0;
        m_valid = 1'b0;
        m_data  = 32'd0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic model_update(input logic rd, input logic [7:0] d, input logic rdy);
        logic        done;
        logic [31:0] w;
        done = 1'b0;
        w    = 32'd0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (rd) begin
            m_bytes.push_back(d);
            m_gap = 0;
            if (m_bytes.size() == 4) begin
                w    = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                done = 1'b1;
                m_bytes.delete();
            end
        end else if (m_bytes.size() > 0) begin
            m_gap++;
            if (m_gap == TMO) begin
                m_fe = 1'b1;
                m_bytes.delete();
            end
        end
        if (done) begin
            if (m_valid && !rdy) m_ov = 1'b1;
            else begin
                m_data  = w;
                m_valid = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs just after the edge
    task automatic step(input logic rd, input logic [7:0] d, input logic rdy);
        rx_done    = rd;
        rx_data    = rd ? d : 8'($urandom);
        word_ready = rdy;
        @(posedge sys_clk);
        model_update(rd, d, rdy);
        #1;
        if (frame_err) fe_seen++;
        if (overrun) ov_seen++;
        check("model", {word_valid, frame_err, overrun, word_data},
              {m_valid, m_fe, m_ov, m_data});
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
    endtask

    task automatic send_word(input logic [31:0] w, input logic rdy);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, t[31:24], rdy);
            t = t << 8;
        end
    endtask

    task automatic do_reset();
        rx_done = 1'b0;
        sys_rst = 1'b1;
        #1;
        check("reset_async", {word_valid, frame_err, overrun, word_data}, 35'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk);
            #1;
            check("reset_hold", {word_valid, frame_err, overrun, word_data}, 35'd0);
        end
        sys_rst = 1'b0;
        model_clear();
    endtask

    initial begin
        int fe_at;

        // Consecutive bytes (T5) then a completion coinciding with ready (T6)
        tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h03, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h04, 1'b1, 1'b1, 32'h01020304, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h05, 1'b1, 1'b0, 32'h01020304, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h06, 1'b1, 1'b0, 32'h01020304, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'h07, 1'b1, 1'b0, 32'h01020304, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h08, 1'b1, 1'b1, 32'h05060708, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 32'h05060708, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'h11, 1'b0, 1'b1, 32'h05060708, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'h12, 1'b0, 1'b1, 32'h05060708, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'h13, 1'b0, 1'b1, 32'h05060708, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'h14, 1'b1, 1'b1, 32'h11121314, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h11121314, 1'b0, 1'b0};

        repeat (2) @(posedge sys_clk);
        #1;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rd, tbl[i].d, tbl[i].rdy);
            check($sformatf("vec%0d", i), {word_valid, frame_err, overrun, word_data},
                  {tbl[i].v, tbl[i].fe, tbl[i].ov, tbl[i].data});
        end

        // T1: baud-spaced bytes, valid exactly one cycle
        step(1'b1, 8'hAA, 1'b1); idle(433, 1'b1);
        step(1'b1, 8'hBB, 1'b1); idle(433, 1'b1);
        step(1'b1, 8'hCC, 1'b1); idle(433, 1'b1);
        step(1'b1, 8'hDD, 1'b1);
        check("t1_word", {31'd0, word_valid, word_data}, {31'd0, 1'b1, 32'hAABBCCDD});
        step(1'b0, 8'h00, 1'b1);
        check("t1_valid_drop", {31'd0, word_valid}, 32'd0);

        // T2: held word survives a dropped second word
        ov_seen = 0;
        send_word(32'h12345678, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        idle(3, 1'b0);
        check("t2_overrun_cnt", 32'(ov_seen), 32'd1);
        check("t2_held", {31'd0, word_valid, word_data}, {31'd0, 1'b1, 32'h12345678});
        step(1'b0, 8'h00, 1'b1);
        check("t2_xfer", {31'd0, word_valid, word_data}, {31'd0, 1'b0, 32'h12345678});

        // T3: partial word aborted after the gap
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        fe_seen = 0;
        fe_at = -1;
        for (int i = 1; i <= 9000; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (frame_err && fe_at < 0) fe_at = i;
        end
        check("t3_fe_cnt", 32'(fe_seen), 32'd1);
        check("t3_fe_gap", 32'(fe_at), 32'(TMO));
        send_word(32'h12345678, 1'b1);
        check("t3_word", {31'd0, word_valid, word_data}, {31'd0, 1'b1, 32'h12345678});
        step(1'b0, 8'h00, 1'b1);
        check("t3_no_extra_fe", 32'(fe_seen), 32'd1);

        // Byte landing on the timeout cycle is accepted
        fe_seen = 0;
        step(1'b1, 8'h5A, 1'b1);
        idle(TMO - 1, 1'b1);
        step(1'b1, 8'h6B, 1'b1);
        step(1'b1, 8'h7C, 1'b1);
        step(1'b1, 8'h8D, 1'b1);
        check("edge_word", {31'd0, word_valid, word_data}, {31'd0, 1'b1, 32'h5A6B7C8D});
        check("edge_no_fe", 32'(fe_seen), 32'd0);
        step(1'b0, 8'h00, 1'b1);

        // T4: reset mid-word with a word held
        send_word(32'h01020304, 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        do_reset();
        send_word(32'hA1B2C3D4, 1'b1);
        check("t4_word", {31'd0, word_valid, word_data}, {31'd0, 1'b1, 32'hA1B2C3D4});

        // Random traffic against the model
        for (int i = 0; i < 4000; i++)
            step(($urandom % 3) == 0, 8'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
